// File: rtl/fpu_class_arb.sv
// Two-port round-robin front end for an IEEE-754 single-precision classifier.
// One result register; a new operand may be accepted whenever that register is empty or draining.
module fpu_class_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid_i,
    input  logic [31:0]      req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [31:0]      req1_data_i,
    output logic             req1_ready_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_id_o,
    output logic [CNT_W-1:0] gnt_cnt0_o,
    output logic [CNT_W-1:0] gnt_cnt1_o
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_gnt;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_id;
    logic [CNT_W-1:0]   r_cnt0;
    logic [CNT_W-1:0]   r_cnt1;

    logic               w_can_accept;
    logic               w_gnt_valid;
    logic               w_gnt_id;
    logic               w_hs;
    logic               w_hs0;
    logic               w_hs1;
    logic [31:0]        w_sel_data;
    logic [31:0]        w_class;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [31:0] classify(input logic [31:0] f);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] c;
        s = f[31];
        e = f[30:23];
        m = f[22:0];
        c = '0;
        if (e == 8'hFF) begin
            if (m == '0)      c[s ? 0 : 7] = 1'b1;
            else if (m[22])   c[9] = 1'b1;
            else              c[8] = 1'b1;
        end else if (e == 8'h00) begin
            if (m == '0)      c[s ? 3 : 4] = 1'b1;
            else              c[s ? 2 : 5] = 1'b1;
        end else begin
            c[s ? 1 : 6] = 1'b1;
        end
        return c;
    endfunction

    // Readies are forced low while reset is held, independent of the state register.
    assign w_can_accept = rst_n & ((r_state == EMPTY) | rsp_ready_i);

    always_comb begin
        w_gnt_valid = req0_valid_i | req1_valid_i;
        w_gnt_id    = 1'b0;
        if (req0_valid_i && req1_valid_i) w_gnt_id = ~r_last_gnt;
        else if (req1_valid_i)            w_gnt_id = 1'b1;
    end

    assign w_hs       = w_can_accept & w_gnt_valid;
    assign w_hs0      = w_hs & ~w_gnt_id;
    assign w_hs1      = w_hs & w_gnt_id;
    assign w_sel_data = w_gnt_id ? req1_data_i : req0_data_i;
    assign w_class    = classify(w_sel_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        req0_ready_o = w_hs0;
        req1_ready_o = w_hs1;
        rsp_valid_o  = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_hs) w_next_state = FULL;
            end
            FULL: begin
                rsp_valid_o = 1'b1;
                if (!w_hs && rsp_ready_i) w_next_state = EMPTY;
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // Result payload and priority only move on a handshake; draining leaves the last values visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= '0;
            r_rsp_id   <= 1'b0;
            r_last_gnt <= 1'b1;
        end else if (w_hs) begin
            r_rsp_data <= w_class;
            r_rsp_id   <= w_gnt_id;
            r_last_gnt <= w_gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_hs0 && r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + CNT_ONE;
            if (w_hs1 && r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + CNT_ONE;
        end
    end

    assign rsp_data_o = r_rsp_data;
    assign rsp_id_o   = r_rsp_id;
    assign gnt_cnt0_o = r_cnt0;
    assign gnt_cnt1_o = r_cnt1;

endmodule

// File: doc/fpu_class_arb.md
FPU_CLASS_ARB -- requirements
Module: fpu_class_arb

Interface
REQ-001 SHALL have parameter: CNT_W, default 16, width of per-port grant counters.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: req0_valid_i  input  1  port 0 operand valid.
REQ-005 SHALL have port: req0_data_i  input  32  port 0 IEEE-754 single operand.
REQ-006 SHALL have port: req0_ready_o  output  1  port 0 operand accepted this cycle when high with valid.
REQ-007 SHALL have port: req1_valid_i  input  1  port 1 operand valid.
REQ-008 SHALL have port: req1_data_i  input  32  port 1 IEEE-754 single operand.
REQ-009 SHALL have port: req1_ready_o  output  1  port 1 accept.
REQ-010 SHALL have port: rsp_valid_o  output  1  result register holds a valid result.
REQ-011 SHALL have port: rsp_ready_i  input  1  consumer takes result.
REQ-012 SHALL have port: rsp_data_o  output  32  one-hot class mask.
REQ-013 SHALL have port: rsp_id_o  output  1  requester index of held result.
REQ-014 SHALL have ports: gnt_cnt0_o, gnt_cnt1_o  output  CNT_W  accepted-operand counts per port.

Function
REQ-015 Class mask SHALL be: bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0, bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 signaling NaN (exp all-ones, frac!=0, frac[22]=0), bit9 quiet NaN (frac[22]=1); bits 31:10 zero; exactly one of bits 9:0 set; NaN sign ignored.
REQ-016 Block SHALL be a two-state FSM on one result register: EMPTY (rsp_valid_o=0), FULL (rsp_valid_o=1).
REQ-017 can_accept SHALL be (state==EMPTY) or (state==FULL and rsp_ready_i).
REQ-018 Arbitration SHALL be round-robin: one valid port -> that port granted; both valid -> port not equal last_gnt granted; none -> no grant.
REQ-019 reqN_ready_o SHALL equal can_accept AND grant==N; never both high; may depend on other port's valid, never on any data input.
REQ-020 Handshake on port N (valid&ready at edge) SHALL load class(reqN_data_i) into rsp_data_o, N into rsp_id_o, set FULL, set last_gnt=N; latency one edge.
REQ-021 last_gnt SHALL change only on a handshake; idle cycles do not move priority.
REQ-022 FULL with rsp_ready_i=1 and no handshake SHALL go EMPTY; rsp_data_o/rsp_id_o hold last values.
REQ-023 FULL with rsp_ready_i=1 and a handshake same cycle SHALL stay FULL with new result, no bubble (full throughput one per cycle).
REQ-024 FULL with rsp_ready_i=0 SHALL hold rsp_valid_o, rsp_data_o, rsp_id_o stable; both ready outputs low.
REQ-025 gnt_cntN_o SHALL increment by 1 on each port-N handshake, saturating at 2^CNT_W-1 (no wrap).
REQ-026 Requester dropping valid without handshake SHALL not affect state, priority or counters.

Reset
REQ-027 rst_n low SHALL asynchronously force: state EMPTY, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, last_gnt=1 (port 0 wins first tie), both counters 0; ready outputs low while rst_n low.
REQ-028 Reset mid-operation SHALL discard a held result without presenting it; first cycle after release behaves as EMPTY.

Verification
REQ-029 Port0 only, data 0x3F800000, rsp_ready_i=1 -> next cycle rsp_valid_o=1, rsp_data_o=0x00000040, rsp_id_o=0, gnt_cnt0_o=1.
REQ-030 Both valid continuously from reset, rsp_ready_i=1, data0=0xFF800000, data1=0x7FC00000 -> ids 0,1,0,1 alternating every cycle, masks 0x001 / 0x200, no bubbles.
REQ-031 FULL with rsp_ready_i=0 for 5 cycles, both ports valid -> both ready low, outputs stable; ready_i=1 -> next granted per round-robin, same-cycle reload.
REQ-032 Class sweep: 0x80000000->0x008, 0x00000001->0x020, 0x80400000->0x004, 0x7F800001->0x100, 0xFF800000->0x001, 0x7F800000->0x080.
REQ-033 CNT_W=2, port0 5 handshakes -> gnt_cnt0_o reads 1,2,3,3,3.
REQ-034 Assert rst_n low while FULL and rsp_ready_i=0 -> rsp_valid_o=0 immediately (no clock edge), counters 0, after release port 0 wins tie.
